// File: rtl/cymometer_pkg.sv
// Shared types and constants for the equal-precision cymometer.
package cymometer_pkg;

  typedef enum logic [1:0] {
    ModeFreq   = 2'd0,
    ModePeriod = 2'd1,
    ModePulse  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    StWaitHigh,
    StArmed,
    StOpen,
    StClose
  } gate_e;

  localparam int unsigned FrameBits = 40;
  localparam logic [63:0] NsPerSec  = 64'd1_000_000_000;

  // Saturating 32-bit increment.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_divider_64.sv
// 64/64 restoring divider, one quotient bit per cycle.
module seq_divider_64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        start_i,
  input  logic [63:0] num_i,
  input  logic [63:0] den_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] quot_o
);

  logic [63:0] rem_q, rem_d, quot_q, quot_d, den_q, den_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [64:0] shifted, trial;

  // Next-state: load on start, otherwise shift-subtract while busy.
  always_comb begin
    shifted = {rem_q, quot_q[63]};
    trial   = shifted - {1'b0, den_q};
    rem_d   = rem_q;
    quot_d  = quot_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start_i && !busy_q) begin
      rem_d  = '0;
      quot_d = num_i;
      den_d  = den_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // trial[64] set means the partial remainder was below the divisor.
      rem_d  = trial[64] ? shifted[63:0] : trial[63:0];
      quot_d = {quot_q[62:0], ~trial[64]};
      cnt_d  = cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State register; clr_i abandons any division in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/cymometer_core_top.sv
// Equal-precision frequency/period/pulse meter with keypad and serial result link.
module cymometer_core_top
  import cymometer_pkg::*;
#(
  parameter logic [25:0] DIV_N        = 26'd10,
  parameter logic [29:0] CNT_GATE_LOW = 30'd12_500_000,
  parameter logic [29:0] CLK_FS_FREQ  = 30'd100_000_000,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       clk_fx,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       oled_clk,
  output logic       oled_dat,
  output logic       oled_dcn,
  output logic       oled_rst,
  output logic       clk_out1,
  output logic       clk_out2
);

  logic [25:0] div1_q, div2_q;
  logic        clk_out1_q, clk_out2_q, oled_rst_q;
  logic [3:0]  col_s1_q, col_s2_q, col_last_q;
  logic [19:0] deb_cnt_q;
  logic        key_valid, key_fire, restart;
  mode_e       mode_q, res_mode_q;
  logic        selftest_q;
  logic        fx_s1_q, fx_s2_q, fx_s3_q, fx_rise;
  logic [30:0] soft_cnt_q;
  logic        soft_q;
  gate_e       gate_q, gate_d;
  logic [31:0] fs_q, fs_d, fx_q, fx_d, hi_q, hi_d;
  logic        meas_done_q, meas_done_d, meas_go;
  logic [63:0] num, den, quot;
  logic        div_start, div_busy, div_done;
  logic [31:0] res_q;
  logic        res_valid_q;
  logic        tx_active_q, tx_active_d, pend_q, pend_d;
  logic [1:0]  tx_phase_q, tx_phase_d;
  logic [5:0]  tx_bit_q, tx_bit_d;
  logic [39:0] tx_shift_q, tx_shift_d, pend_frame_q, pend_frame_d;

  assign row = 4'b1110;

  // Reference clock dividers and display reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div1_q     <= '0;
      div2_q     <= '0;
      clk_out1_q <= 1'b0;
      clk_out2_q <= 1'b0;
      oled_rst_q <= 1'b0;
    end else begin
      oled_rst_q <= 1'b1;
      if (div1_q == (DIV_N >> 1) - 26'd1) begin
        div1_q     <= '0;
        clk_out1_q <= ~clk_out1_q;
      end else begin
        div1_q <= div1_q + 26'd1;
      end
      if (div2_q == DIV_N - 26'd1) begin
        div2_q     <= '0;
        clk_out2_q <= ~clk_out2_q;
      end else begin
        div2_q <= div2_q + 26'd1;
      end
    end
  end

  // Only single-zero codes are keys; fire once when the count reaches the threshold.
  always_comb begin
    unique case (col_last_q)
      4'b1101, 4'b1011, 4'b0111, 4'b1110: key_valid = 1'b1;
      default:                            key_valid = 1'b0;
    endcase
    key_fire = key_valid && (col_s2_q == col_last_q) && (deb_cnt_q == DEBOUNCE_CYC - 20'd1);
    restart  = key_fire;
  end

  // Keypad column synchronizer and stability counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_s1_q   <= 4'hF;
      col_s2_q   <= 4'hF;
      col_last_q <= 4'hF;
      deb_cnt_q  <= '0;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
      if (col_s2_q != col_last_q) begin
        col_last_q <= col_s2_q;
        deb_cnt_q  <= '0;
      end else if (deb_cnt_q != DEBOUNCE_CYC) begin
        deb_cnt_q <= deb_cnt_q + 20'd1;
      end
    end
  end

  // Mode and self-test selection from accepted keys.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q     <= ModeFreq;
      selftest_q <= 1'b0;
    end else if (key_fire) begin
      unique case (col_last_q)
        4'b1101: mode_q     <= ModeFreq;
        4'b1011: mode_q     <= ModePeriod;
        4'b0111: mode_q     <= ModePulse;
        4'b1110: selftest_q <= ~selftest_q;
        default: ;
      endcase
    end
  end

  // Measured-signal synchronizer and rising-edge detect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fx_s1_q <= 1'b0;
      fx_s2_q <= 1'b0;
      fx_s3_q <= 1'b0;
    end else begin
      fx_s1_q <= selftest_q ? clk_out1_q : clk_fx;
      fx_s2_q <= fx_s1_q;
      fx_s3_q <= fx_s2_q;
    end
  end

  assign fx_rise = fx_s2_q && !fx_s3_q;

  // Soft gate: high for 2*CNT_GATE_LOW, low for CNT_GATE_LOW; restarts high on a key.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart) begin
      soft_cnt_q <= '0;
      soft_q     <= 1'b1;
    end else if (soft_q && soft_cnt_q == {CNT_GATE_LOW, 1'b0} - 31'd1) begin
      soft_cnt_q <= '0;
      soft_q     <= 1'b0;
    end else if (!soft_q && soft_cnt_q == {1'b0, CNT_GATE_LOW} - 31'd1) begin
      soft_cnt_q <= '0;
      soft_q     <= 1'b1;
    end else begin
      soft_cnt_q <= soft_cnt_q + 31'd1;
    end
  end

  // Actual gate FSM and counters; a window with no fx edge ends with zero counts.
  always_comb begin
    gate_d      = gate_q;
    fs_d        = fs_q;
    fx_d        = fx_q;
    hi_d        = hi_q;
    meas_done_d = 1'b0;
    unique case (gate_q)
      StWaitHigh: if (soft_q) gate_d = StArmed;
      StArmed: begin
        fs_d = '0;
        fx_d = '0;
        hi_d = '0;
        if (!soft_q) begin
          meas_done_d = 1'b1;
          gate_d      = StWaitHigh;
        end else if (fx_rise) begin
          gate_d = StOpen;
        end
      end
      StOpen, StClose: begin
        fs_d = sat_inc(fs_q);
        if (fx_rise) fx_d = sat_inc(fx_q);
        if (fx_s2_q) hi_d = sat_inc(hi_q);
        if (gate_q == StOpen) begin
          if (!soft_q) begin
            gate_d      = fx_rise ? StWaitHigh : StClose;
            meas_done_d = fx_rise;
          end
        end else if (fx_rise || soft_q) begin
          // soft_q high here means fx stopped before the gate could close
          gate_d      = StWaitHigh;
          meas_done_d = 1'b1;
        end
      end
      default: gate_d = StWaitHigh;
    endcase
  end

  // Gate state and counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart) begin
      gate_q      <= StWaitHigh;
      fs_q        <= '0;
      fx_q        <= '0;
      hi_q        <= '0;
      meas_done_q <= 1'b0;
    end else begin
      gate_q      <= gate_d;
      fs_q        <= fs_d;
      fx_q        <= fx_d;
      hi_q        <= hi_d;
      meas_done_q <= meas_done_d;
    end
  end

  // Scaled numerator/denominator for the current mode.
  always_comb begin
    unique case (mode_q)
      ModePeriod: begin
        num = NsPerSec * 64'(fs_q);
        den = 64'(CLK_FS_FREQ) * 64'(fx_q);
      end
      ModePulse: begin
        num = NsPerSec * 64'(hi_q);
        den = 64'(CLK_FS_FREQ) * 64'(fx_q);
      end
      default: begin
        num = 64'(CLK_FS_FREQ) * 64'(fx_q);
        den = 64'(fs_q);
      end
    endcase
  end

  assign meas_go   = meas_done_q && !restart;
  assign div_start = meas_go && (den != 64'd0) && !div_busy;

  seq_divider_64 u_div (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .clr_i   (restart),
    .start_i (div_start),
    .num_i   (num),
    .den_i   (den),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (quot)
  );

  // Result capture: zero divisor skips the divider, quotient saturates to 32 bits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res_q       <= '0;
      res_mode_q  <= ModeFreq;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (meas_go && den == 64'd0) begin
        res_q       <= '0;
        res_mode_q  <= mode_q;
        res_valid_q <= 1'b1;
      end else if (div_done && !restart) begin
        res_q       <= (quot[63:32] != 32'd0) ? 32'hFFFF_FFFF : quot[31:0];
        res_mode_q  <= mode_q;
        res_valid_q <= 1'b1;
      end
    end
  end

  // Frame sequencer: 4 sys_clk per bit, shift on the oled_clk falling edge.
  always_comb begin
    tx_active_d  = tx_active_q;
    tx_phase_d   = tx_phase_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    pend_d       = pend_q;
    pend_frame_d = pend_frame_q;
    if (res_valid_q) begin
      pend_d       = 1'b1;
      pend_frame_d = {6'b0, res_mode_q, res_q};
    end
    if (tx_active_q) begin
      tx_phase_d = tx_phase_q + 2'd1;
      if (tx_phase_q == 2'd3) begin
        tx_shift_d = tx_shift_q << 1;
        tx_bit_d   = tx_bit_q + 6'd1;
        if (tx_bit_q == 6'(FrameBits - 1)) tx_active_d = 1'b0;
      end
    end
    if (!tx_active_d && pend_d) begin
      tx_active_d = 1'b1;
      tx_phase_d  = '0;
      tx_bit_d    = '0;
      tx_shift_d  = pend_frame_d;
      pend_d      = 1'b0;
    end
  end

  // Serial link registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_active_q  <= 1'b0;
      tx_phase_q   <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      pend_q       <= 1'b0;
      pend_frame_q <= '0;
    end else begin
      tx_active_q  <= tx_active_d;
      tx_phase_q   <= tx_phase_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      pend_q       <= pend_d;
      pend_frame_q <= pend_frame_d;
    end
  end

  assign oled_clk = tx_active_q && tx_phase_q[1];
  assign oled_dat = tx_active_q && tx_shift_q[39];
  assign oled_dcn = !(tx_active_q && tx_bit_q < 6'd8);
  assign oled_rst = oled_rst_q;
  assign clk_out1 = clk_out1_q;
  assign clk_out2 = clk_out2_q;

endmodule

// File: tb/tb_cymometer_core_top.sv
// Directed bench: frames decoded from the serial link against hand-computed results.
module tb_cymometer_core_top;

  logic       sys_clk, sys_rst, clk_fx, fx_run;
  logic [3:0] col, row;
  logic       oled_clk, oled_dat, oled_dcn, oled_rst, clk_out1, clk_out2;

  int checks = 0;
  int errors = 0;

  logic [39:0] frames[$];
  logic        flags[$];
  logic [38:0] mon_sh;
  int          mon_bits;
  logic        mon_dcn_bad, oclk_prev;
  int          p;
  int          n;

  cymometer_core_top #(
    .DIV_N        (26'd10),
    .CNT_GATE_LOW (30'd1000),
    .CLK_FS_FREQ  (30'd50_000_000),
    .DEBOUNCE_CYC (20'd16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clk_fx   (clk_fx),
    .col      (col),
    .row      (row),
    .oled_clk (oled_clk),
    .oled_dat (oled_dat),
    .oled_dcn (oled_dcn),
    .oled_rst (oled_rst),
    .clk_out1 (clk_out1),
    .clk_out2 (clk_out2)
  );

  // 50 MHz system clock.
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // 5 MHz measured signal, offset from the system clock edges.
  initial begin
    clk_fx = 1'b0;
    #3;
    forever #100 clk_fx = fx_run ? ~clk_fx : 1'b0;
  end

  // Frame monitor: capture on oled_clk rising, track D/C# per bit position.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      mon_bits    <= 0;
      mon_dcn_bad <= 1'b0;
    end else if (oled_clk && !oclk_prev) begin
      if (mon_bits == 39) begin
        frames.push_back({mon_sh, oled_dat});
        flags.push_back(mon_dcn_bad || (oled_dcn !== 1'b1));
        mon_bits    <= 0;
        mon_dcn_bad <= 1'b0;
      end else begin
        mon_sh   <= {mon_sh[37:0], oled_dat};
        mon_bits <= mon_bits + 1;
        if ((mon_bits < 8) ? (oled_dcn !== 1'b0) : (oled_dcn !== 1'b1)) mon_dcn_bad <= 1'b1;
      end
    end
    oclk_prev <= oled_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] hdr, input logic [31:0] res);
    int          k;
    logic [39:0] f;
    logic        bad;
    k = 0;
    while (frames.size() == 0 && k < 8000) begin
      @(negedge sys_clk);
      k++;
    end
    check({tag, "_arrived"}, 64'(frames.size() != 0), 64'd1);
    if (frames.size() != 0) begin
      f   = frames.pop_front();
      bad = flags.pop_front();
    end else begin
      f   = '1;
      bad = 1'b1;
    end
    check({tag, "_hdr"}, 64'(f[39:32]), 64'(hdr));
    check({tag, "_res"}, 64'(f[31:0]), 64'(res));
    check({tag, "_dcn"}, 64'(bad), 64'd0);
  endtask

  // Hold a key long enough to debounce, release, then drop any older frames.
  task automatic press(input logic [3:0] c);
    @(negedge sys_clk);
    col = c;
    repeat (20) @(negedge sys_clk);
    col = 4'b1111;
    repeat (500) @(negedge sys_clk);
    frames.delete();
    flags.delete();
  endtask

  // Cycles between two rising edges of the selected reference clock.
  task automatic ref_period(input logic sel, output int per);
    logic prev, cur, found;
    int   t0;
    per   = -1;
    found = 1'b0;
    t0    = 0;
    prev  = sel ? clk_out2 : clk_out1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      cur = sel ? clk_out2 : clk_out1;
      if (cur && !prev) begin
        if (found) begin
          per = i - t0;
          break;
        end
        found = 1'b1;
        t0    = i;
      end
      prev = cur;
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    col     = 4'b1111;
    fx_run  = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_oled_rst", 64'(oled_rst), 64'd0);
    check("rst_oled_clk", 64'(oled_clk), 64'd0);
    check("rst_oled_dat", 64'(oled_dat), 64'd0);
    check("rst_oled_dcn", 64'(oled_dcn), 64'd1);
    check("rst_clk_out1", 64'(clk_out1), 64'd0);
    check("rst_clk_out2", 64'(clk_out2), 64'd0);
    check("row_drive", 64'(row), 64'hE);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("oled_rst_release", 64'(oled_rst), 64'd1);

    check_frame("freq", 8'h00, 32'd5_000_000);

    press(4'b1011);
    check_frame("period", 8'h01, 32'd200);

    press(4'b0111);
    check_frame("pulse", 8'h02, 32'd100);

    fx_run = 1'b0;
    press(4'b1110);
    ref_period(1'b0, p);
    check("clk_out1_period", 64'(p), 64'd10);
    ref_period(1'b1, p);
    check("clk_out2_period", 64'(p), 64'd20);
    press(4'b1101);
    check_frame("selftest_freq", 8'h00, 32'd5_000_000);

    press(4'b1110);
    check_frame("no_signal", 8'h00, 32'd0);

    fx_run = 1'b1;
    press(4'b1011);
    n = 0;
    while (oled_dcn !== 1'b0 && n < 8000) begin
      @(negedge sys_clk);
      n++;
    end
    check("midframe_header", 64'(oled_dcn), 64'd0);
    repeat (6) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_oled_clk", 64'(oled_clk), 64'd0);
    check("midrst_oled_dcn", 64'(oled_dcn), 64'd1);
    check("midrst_oled_dat", 64'(oled_dat), 64'd0);
    check("midrst_oled_rst", 64'(oled_rst), 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    frames.delete();
    flags.delete();
    check_frame("after_rst", 8'h00, 32'd5_000_000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
